slow_mem_responder: RTL
=======================

# slow_mem_responder

Memory-side responder for the 128-bit line protocol driven by the L2 cache (`mem_read`/`mem_write`/`mem_addr[31:4]`/`mem_wdata`/`mem_rdata`/`mem_ready`). It stores cache lines in an internal array and completes each captured request after a fixed, parameterised latency with a one-cycle `mem_ready` pulse. One instance is used per memory side (I and D) in the synthesizable system-level bench and in FPGA bring-up. It replaces the behavioural slow-memory model.

## Interface
- `LINE_W`, 128: line width in bits; fixed by the protocol.
- `IDX_W`, 10: index bits taken from the line address; the array holds 2^IDX_W lines.
- `LATENCY`, 8: cycles from request capture to `mem_ready`; legal range 1..255.
- `clk` in 1: single clock; all logic is rising-edge.
- `rst_n` in 1: synchronous, active-low reset.
- `mem_read` in 1: line read request; held by the initiator until `mem_ready`.
- `mem_write` in 1: line write request; held by the initiator until `mem_ready`.
- `mem_addr` in [31:4]: line address; only `[IDX_W+3:4]` is used.
- `mem_wdata` in LINE_W: write line; sampled at capture.
- `mem_rdata` out LINE_W: read line; valid in the `mem_ready` cycle and held afterwards.
- `mem_ready` out 1: one-cycle completion pulse.
- `init_we` in 1: backdoor line write used by the bench for preload.
- `init_addr` in IDX_W: backdoor line index.
- `init_data` in LINE_W: backdoor line data.
- `rd_cnt` out 16: completed reads; saturates at 0xFFFF.
- `wr_cnt` out 16: completed writes; saturates at 0xFFFF.

## Operation
- FSM states:
  - IDLE: if `mem_read | mem_write` is high, capture op, index and wdata. Go to RESP if LATENCY==1, otherwise go to BUSY with cnt=LATENCY-1.
  - BUSY: decrement cnt. When cnt==1, go to RESP.
  - RESP: `mem_ready`=1 for this cycle only, then return to IDLE.
- Array access happens on the edge entering RESP:
  - write: `array[idx] <= wdata`.
  - read: `mem_rdata <= array[idx]`.
  - Both outputs are registered.
- Read and write asserted together: treat as a write. No error is flagged.
- Inputs are ignored outside IDLE. Changing or dropping the request mid-transaction does not abort it; the captured op completes.
- Index wrap-around: address bits above IDX_W+3 are ignored, so lines alias modulo 2^IDX_W.
- Counters: `rd_cnt` or `wr_cnt` increments on the edge entering RESP, with saturation.
- Backdoor: `init_we` writes `array[init_addr]` on any edge, including while `rst_n`=0. If it collides on the same index with a protocol write on the same edge, the protocol write wins.
- Reset (`rst_n`=0 on an edge):
  - state=IDLE, cnt=0, `mem_ready`=0, `mem_rdata`=0, `rd_cnt`=`wr_cnt`=0.
  - The array is not cleared.
  - An in-flight transaction is aborted; an uncommitted write is dropped.

## Timing
- Request high in cycle t (sampled at the edge ending t) produces `mem_ready` high in cycle t+LATENCY, for exactly one cycle.
- `mem_rdata` carries the line in that same cycle.
- The initiator deasserts its request in cycle t+LATENCY+1. A request still high in that cycle (IDLE) is captured as a new transaction.
- Back-to-back throughput is one line per LATENCY+1 cycles.
- Read-after-write to the same line returns the new data. The write commits before IDLE resumes.
- `mem_rdata` holds its value after the `mem_ready` cycle until the next read completes or reset.
- No combinational path from any input to any output.

## Structure
- Package `slow_mem_pkg` holds:
  - `LINE_W` = 128
  - `DEFAULT_LATENCY` = 8
  - the state enum {IDLE, BUSY, RESP}
  - `CNT_W` = 8
- Sub-module `line_ram`: 2^IDX_W × LINE_W array.
  - Write port A is the protocol write and has priority.
  - Write port B is the backdoor.
  - One registered read port.
- Top-level holds the FSM, latency counter, capture registers and statistics counters.

## Test plan
- Preload via backdoor `array[5]=0x0123…CDEF`, then read `mem_addr`=0x0000005 with LATENCY=8 -> `mem_ready` only in cycle t+8, `mem_rdata`=0x0123…CDEF, `rd_cnt`=1.
- Write line 0x3FF with 0xA5…A5, then read 0x3FF on the next IDLE cycle -> data 0xA5…A5. Reading `mem_addr`=0x00007FF (alias) also returns 0xA5…A5.
- `mem_read` and `mem_write` both high, addr 2, wdata 0x11…11 -> treated as a write. `wr_cnt`=1, `rd_cnt` unchanged, and a later read of line 2 returns 0x11…11.
- Drop `mem_read` after 2 cycles with LATENCY=8 -> `mem_ready` still pulses in cycle t+8. The request held high in cycle t+9 is captured, and the next `mem_ready` comes in cycle t+17.
- Pull `rst_n` low during BUSY of a write to line 7 (old value 0x0) -> all outputs reset, line 7 still reads 0x0, no `mem_ready` pulse.
- LATENCY=1 build: read request in cycle t -> `mem_ready` in t+1. Issue 65536 reads -> `rd_cnt` saturates at 0xFFFF.

Source files
------------

// File: rtl/slow_mem_responder_pkg.sv
// Shared constants, state encoding and helpers for the slow line-memory responder.
package slow_mem_pkg;

  localparam int LINE_W          = 128;
  localparam int DEFAULT_LATENCY = 8;
  localparam int CNT_W           = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_e;

  // Saturating increment for the 16-bit statistics counters.
  function automatic logic [15:0] sat_inc(input logic [15:0] v, input logic [15:0] max);
    return (v >= max) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/slow_mem_responder_if.sv
// Line-protocol bus between the L2 cache (master) and the memory responder (slave).
interface slow_mem_responder_if;
  import slow_mem_pkg::*;

  // Handshake: the master raises mem_read or mem_write with mem_addr/mem_wdata and holds
  // them until mem_ready pulses for one cycle; the slave samples the request only while
  // idle, and mem_rdata is valid in the mem_ready cycle and held until the next read.
  logic              mem_read;
  logic              mem_write;
  logic [31:4]       mem_addr;
  logic [LINE_W-1:0] mem_wdata;
  logic [LINE_W-1:0] mem_rdata;
  logic              mem_ready;

  modport master (
    output mem_read, mem_write, mem_addr, mem_wdata,
    input  mem_rdata, mem_ready
  );

  modport slave (
    input  mem_read, mem_write, mem_addr, mem_wdata,
    output mem_rdata, mem_ready
  );

endinterface

// File: rtl/slow_mem_responder_line_ram.sv
// Line array with a priority protocol write port, a backdoor write port and one registered read port.
module line_ram #(
  parameter int IDX_W  = 10,
  parameter int LINE_W = slow_mem_pkg::LINE_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              a_we_i,
  input  logic [IDX_W-1:0]  a_idx_i,
  input  logic [LINE_W-1:0] a_data_i,
  input  logic              b_we_i,
  input  logic [IDX_W-1:0]  b_idx_i,
  input  logic [LINE_W-1:0] b_data_i,
  input  logic              rd_en_i,
  input  logic [IDX_W-1:0]  rd_idx_i,
  output logic [LINE_W-1:0] rd_data_o
);

  logic [LINE_W-1:0] mem_q [2**IDX_W];
  logic [LINE_W-1:0] rd_data_q;
  logic              b_blocked;

  assign b_blocked = a_we_i && (a_idx_i == b_idx_i);

  // The array is never reset; the backdoor keeps working while rst_n is low.
  always_ff @(posedge clk) begin
    if (a_we_i) begin
      mem_q[a_idx_i] <= a_data_i;
    end
    if (b_we_i && !b_blocked) begin
      mem_q[b_idx_i] <= b_data_i;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_data_q <= '0;
    end else if (rd_en_i) begin
      rd_data_q <= mem_q[rd_idx_i];
    end
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/slow_mem_responder.sv
// Memory-side responder: captures one line request, waits LATENCY cycles, then pulses mem_ready.
module slow_mem_responder
  import slow_mem_pkg::*;
#(
  parameter int          IDX_W   = 10,
  parameter int          LATENCY = DEFAULT_LATENCY,
  parameter logic [15:0] CNT_MAX = 16'hFFFF
) (
  input  logic                clk,
  input  logic                rst_n,
  slow_mem_responder_if.slave mem,
  input  logic                init_we,
  input  logic [IDX_W-1:0]    init_addr,
  input  logic [LINE_W-1:0]   init_data,
  output logic [15:0]         rd_cnt,
  output logic [15:0]         wr_cnt,
  output state_e              dbg_state_o
);

  localparam logic [1:0]       ST_IDLE = IDLE;
  localparam logic [1:0]       ST_BUSY = BUSY;
  localparam logic [1:0]       ST_RESP = RESP;
  localparam logic [CNT_W-1:0] LAT_M1  = CNT_W'(LATENCY - 1);

  logic [1:0]        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              wr_q;
  logic [IDX_W-1:0]  idx_q;
  logic [LINE_W-1:0] wdata_q;
  logic              ready_q;
  logic [15:0]       rd_cnt_q, wr_cnt_q;

  logic              req;
  logic              in_idle;
  logic              enter_resp;
  logic              acc_wr;
  logic [IDX_W-1:0]  acc_idx;
  logic [LINE_W-1:0] acc_wdata;
  logic              commit_we;
  logic              commit_re;
  logic [LINE_W-1:0] rdata;
  logic              unused_addr_hi;

  assign req            = mem.mem_read | mem.mem_write;
  assign in_idle        = (state_q == ST_IDLE);
  assign unused_addr_hi = ^mem.mem_addr[31:IDX_W+4];

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    enter_resp = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req) begin
          if (LATENCY == 1) begin
            state_d    = ST_RESP;
            enter_resp = 1'b1;
          end else begin
            state_d = ST_BUSY;
            cnt_d   = LAT_M1;
          end
        end
      end
      ST_BUSY: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d    = ST_RESP;
          enter_resp = 1'b1;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // With LATENCY==1 the array is accessed on the capture edge, so take the live inputs.
  assign acc_wr    = in_idle ? mem.mem_write              : wr_q;
  assign acc_idx   = in_idle ? mem.mem_addr[IDX_W+3:4]    : idx_q;
  assign acc_wdata = in_idle ? mem.mem_wdata              : wdata_q;
  assign commit_we = enter_resp & acc_wr & rst_n;
  assign commit_re = enter_resp & ~acc_wr;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      wr_q     <= 1'b0;
      idx_q    <= '0;
      wdata_q  <= '0;
      ready_q  <= 1'b0;
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ready_q <= enter_resp;
      if (in_idle && req) begin
        wr_q    <= mem.mem_write;
        idx_q   <= mem.mem_addr[IDX_W+3:4];
        wdata_q <= mem.mem_wdata;
      end
      if (enter_resp) begin
        if (acc_wr) begin
          wr_cnt_q <= sat_inc(wr_cnt_q, CNT_MAX);
        end else begin
          rd_cnt_q <= sat_inc(rd_cnt_q, CNT_MAX);
        end
      end
    end
  end

  line_ram #(
    .IDX_W  (IDX_W),
    .LINE_W (LINE_W)
  ) u_ram (
    .clk       (clk),
    .rst_n     (rst_n),
    .a_we_i    (commit_we),
    .a_idx_i   (acc_idx),
    .a_data_i  (acc_wdata),
    .b_we_i    (init_we),
    .b_idx_i   (init_addr),
    .b_data_i  (init_data),
    .rd_en_i   (commit_re),
    .rd_idx_i  (acc_idx),
    .rd_data_o (rdata)
  );

  assign mem.mem_rdata = rdata;
  assign mem.mem_ready = ready_q;
  assign rd_cnt        = rd_cnt_q;
  assign wr_cnt        = wr_cnt_q;
  assign dbg_state_o   = state_e'(state_q);

endmodule
